// File: rtl/ram_sp_arb_240x32.sv
// ---------------------------------------------------------------------------
// ram_sp_arb_240x32
// Two-requester round-robin arbiter in front of an external 240x32
// single-port RAM, with a built-in zero-fill sequencer.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   clr_i / busy_o           start zero-fill / fill in progress
//   a_* / b_*                requester A/B: req, wr, adr, dat in;
//                            gnt (same cycle), rd_vld (one cycle later) out
//   rd_dat_o                 read data, straight from ram_rd_dat_i
//   err_o                    pulse one cycle after an out-of-range grant
//   ram_*                    RAM side: adr, wr_ena, wr_dat, rd_ena, rd_dat
//
// Grants are combinational in the request cycle and only happen in IDLE.
// While the fill runs, the RAM port belongs to the fill counter and no
// requester is granted.
// ---------------------------------------------------------------------------
module ram_sp_arb_240x32 #(
   parameter int ADR_WD = 8,
   parameter int DAT_WD = 32,
   parameter int DEPTH  = 240
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   output logic              busy_o,
   input  logic              a_req_i,
   input  logic              a_wr_i,
   input  logic [ADR_WD-1:0] a_adr_i,
   input  logic [DAT_WD-1:0] a_dat_i,
   output logic              a_gnt_o,
   output logic              a_rd_vld_o,
   input  logic              b_req_i,
   input  logic              b_wr_i,
   input  logic [ADR_WD-1:0] b_adr_i,
   input  logic [DAT_WD-1:0] b_dat_i,
   output logic              b_gnt_o,
   output logic              b_rd_vld_o,
   output logic [DAT_WD-1:0] rd_dat_o,
   output logic              err_o,
   output logic [ADR_WD-1:0] ram_adr_o,
   output logic              ram_wr_ena_o,
   output logic [DAT_WD-1:0] ram_wr_dat_o,
   output logic              ram_rd_ena_o,
   input  logic [DAT_WD-1:0] ram_rd_dat_i
);

   // One extra bit so DEPTH == 2**ADR_WD still compares correctly.
   localparam logic [ADR_WD:0]   DEPTH_W = (ADR_WD+1)'(DEPTH);
   localparam logic [ADR_WD-1:0] LAST    = ADR_WD'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic              wr;
      logic [ADR_WD-1:0] adr;
      logic [DAT_WD-1:0] dat;
   } cmd_t;

   state_t            state;
   logic [ADR_WD-1:0] clr_cnt;
   logic              busy_q;
   logic              prio_b;     // 1: B wins a tie (A was granted last)
   logic              a_vld_q;
   logic              b_vld_q;
   logic              err_q;

   cmd_t a_cmd, b_cmd, win;
   logic can_gnt, a_gnt, b_gnt, any_gnt, in_rng, acc, fill;

   assign a_cmd = '{wr: a_wr_i, adr: a_adr_i, dat: a_dat_i};
   assign b_cmd = '{wr: b_wr_i, adr: b_adr_i, dat: b_dat_i};

   // ------------------------------------------------------------------
   // Arbitration. A clr_i pulse in IDLE takes the cycle: nothing is
   // granted, the fill starts on the next edge.
   // ------------------------------------------------------------------
   assign can_gnt = (state == IDLE) && !rst && !clr_i;
   assign a_gnt   = can_gnt && a_req_i && (!b_req_i || !prio_b);
   assign b_gnt   = can_gnt && b_req_i && (!a_req_i ||  prio_b);
   assign any_gnt = a_gnt || b_gnt;
   assign win     = b_gnt ? b_cmd : a_cmd;
   assign in_rng  = ({1'b0, win.adr} < DEPTH_W);
   // Out-of-range grants are accepted but never reach the RAM.
   assign acc     = any_gnt && in_rng;
   assign fill    = (state == CLEAR) && !rst;

   assign a_gnt_o = a_gnt;
   assign b_gnt_o = b_gnt;

   // ------------------------------------------------------------------
   // RAM port mux. fill and acc are mutually exclusive because grants
   // need IDLE, so the two enables can never both be high.
   // ------------------------------------------------------------------
   assign ram_wr_ena_o = fill || (acc && win.wr);
   assign ram_rd_ena_o = acc && !win.wr;
   assign ram_adr_o    = fill ? clr_cnt : win.adr;
   assign ram_wr_dat_o = fill ? '0 : win.dat;

   // ------------------------------------------------------------------
   // Fill sequencer: one word per cycle, addresses 0..DEPTH-1. clr_i is
   // only looked at in IDLE, so a second pulse cannot restart or extend
   // a running fill. Reset aborts mid-way; unwritten words keep data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         clr_cnt <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_i) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST) begin
                  state   <= IDLE;
                  clr_cnt <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               clr_cnt <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;

   // ------------------------------------------------------------------
   // Round-robin pointer and response flags. The pointer only moves on
   // a grant, so an idle cycle keeps the current fairness order.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_b  <= 1'b0;
         a_vld_q <= 1'b0;
         b_vld_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (a_gnt)
            prio_b <= 1'b1;
         else if (b_gnt)
            prio_b <= 1'b0;
         a_vld_q <= a_gnt && in_rng && !win.wr;
         b_vld_q <= b_gnt && in_rng && !win.wr;
         err_q   <= any_gnt && !in_rng;
      end
   end

   // Masked by rst so a read in flight when reset hits is dropped
   // immediately rather than showing up during the reset cycle.
   assign a_rd_vld_o = a_vld_q && !rst;
   assign b_rd_vld_o = b_vld_q && !rst;
   assign err_o      = err_q && !rst;
   assign rd_dat_o   = ram_rd_dat_i;

endmodule

// File: tb/tb_ram_sp_arb_240x32.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_arb_240x32
// Directed bench for ram_sp_arb_240x32 with a behavioural 256x32 RAM
// (registered read, read-before-write) hanging off the RAM port.
// Inputs change 1 time unit after posedge, outputs are sampled at negedge.
// ---------------------------------------------------------------------------
module tb_ram_sp_arb_240x32;

   logic        clk = 1'b0;
   logic        rst, clr_i, busy_o;
   logic        a_req_i, a_wr_i, a_gnt_o, a_rd_vld_o;
   logic        b_req_i, b_wr_i, b_gnt_o, b_rd_vld_o;
   logic [7:0]  a_adr_i, b_adr_i, ram_adr_o;
   logic [31:0] a_dat_i, b_dat_i, rd_dat_o, ram_wr_dat_o, ram_rd_dat_i;
   logic        err_o, ram_wr_ena_o, ram_rd_ena_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_sp_arb_240x32 dut (
      .clk(clk), .rst(rst), .clr_i(clr_i), .busy_o(busy_o),
      .a_req_i(a_req_i), .a_wr_i(a_wr_i), .a_adr_i(a_adr_i), .a_dat_i(a_dat_i),
      .a_gnt_o(a_gnt_o), .a_rd_vld_o(a_rd_vld_o),
      .b_req_i(b_req_i), .b_wr_i(b_wr_i), .b_adr_i(b_adr_i), .b_dat_i(b_dat_i),
      .b_gnt_o(b_gnt_o), .b_rd_vld_o(b_rd_vld_o),
      .rd_dat_o(rd_dat_o), .err_o(err_o),
      .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o),
      .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o),
      .ram_rd_dat_i(ram_rd_dat_i)
   );

   // Behavioural RAM, preloaded with A500_0000 + address.
   logic [31:0] mem [256];
   logic [31:0] ram_q = 32'h0;
   initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
   always @(posedge clk) begin
      if (ram_rd_ena_o) ram_q <= mem[ram_adr_o];
      if (ram_wr_ena_o) mem[ram_adr_o] <= ram_wr_dat_o;
   end
   assign ram_rd_dat_i = ram_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      a_req_i = 0; a_wr_i = 0; a_adr_i = 0; a_dat_i = 0;
      b_req_i = 0; b_wr_i = 0; b_adr_i = 0; b_dat_i = 0;
      clr_i = 0;
   endtask

   // Single-cycle access by A (granted immediately when B is quiet).
   task automatic a_acc(input logic wr, input logic [7:0] adr, input logic [31:0] dat);
      idle_in();
      a_req_i = 1; a_wr_i = wr; a_adr_i = adr; a_dat_i = dat;
      @(negedge clk);
      chk("a_acc_gnt", 32'(a_gnt_o), 32'd1);
      tick();
      idle_in();
   endtask

   // A reads adr and expects value one cycle later.
   task automatic a_rd_chk(input string tag, input logic [7:0] adr, input logic [31:0] exp);
      a_acc(1'b0, adr, 32'h0);
      @(negedge clk);
      chk({tag, "_vld"}, 32'(a_rd_vld_o), 32'd1);
      chk(tag, rd_dat_o, exp);
      tick();
   endtask

   logic [1:0] rr_exp [4];

   initial begin
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
      idle_in();
      rst = 1;
      tick();
      // Requests during reset must not be granted or reach the RAM.
      a_req_i = 1; b_req_i = 1;
      @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_gnt",  32'({a_gnt_o, b_gnt_o}), 32'd0);
      chk("rst_ena",  32'({ram_wr_ena_o, ram_rd_ena_o}), 32'd0);
      chk("rst_vld",  32'({a_rd_vld_o, b_rd_vld_o, err_o}), 32'd0);
      tick();
      rst = 0;
      idle_in();
      @(negedge clk);
      chk("idle_ena", 32'({ram_wr_ena_o, ram_rd_ena_o}), 32'd0);
      tick();

      // A writes 12345678 @5, then B reads it back.
      a_req_i = 1; a_wr_i = 1; a_adr_i = 8'd5; a_dat_i = 32'h1234_5678;
      @(negedge clk);
      chk("w5_gnt", 32'({a_gnt_o, b_gnt_o}), 32'b10);
      chk("w5_ena", 32'({ram_wr_ena_o, ram_rd_ena_o}), 32'b10);
      chk("w5_adr", 32'(ram_adr_o), 32'd5);
      chk("w5_dat", ram_wr_dat_o, 32'h1234_5678);
      tick();
      idle_in();
      b_req_i = 1; b_wr_i = 0; b_adr_i = 8'd5;
      @(negedge clk);
      chk("r5_gnt", 32'({a_gnt_o, b_gnt_o}), 32'b01);
      chk("r5_ena", 32'({ram_wr_ena_o, ram_rd_ena_o}), 32'b01);
      tick();
      idle_in();
      @(negedge clk);
      chk("r5_vld", 32'({a_rd_vld_o, b_rd_vld_o}), 32'b01);
      chk("r5_dat", rd_dat_o, 32'h1234_5678);
      tick();

      // Round robin after a fresh reset: A,B,A,B.
      rst = 1;
      tick();
      rst = 0;
      a_req_i = 1; a_adr_i = 8'd10; b_req_i = 1; b_adr_i = 8'd11;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) idle_in();
         @(negedge clk);
         if (k < 4) chk("rr_gnt", 32'({b_gnt_o, a_gnt_o}), 32'(rr_exp[k]));
         if (k > 0) begin
            chk("rr_vld", 32'({b_rd_vld_o, a_rd_vld_o}), 32'(rr_exp[k-1]));
            chk("rr_dat", rd_dat_o, rr_exp[k-1][0] ? 32'hA500_000A : 32'hA500_000B);
         end
         tick();
      end

      // Read then write to the same address back to back: read sees old.
      a_req_i = 1; a_wr_i = 0; a_adr_i = 8'd20;
      b_req_i = 0;
      @(negedge clk);
      chk("rw_rd_gnt", 32'(a_gnt_o), 32'd1);
      tick();
      a_req_i = 0;
      b_req_i = 1; b_wr_i = 1; b_adr_i = 8'd20; b_dat_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rw_wr_ena", 32'({b_gnt_o, ram_wr_ena_o, ram_rd_ena_o}), 32'b110);
      chk("rw_old", rd_dat_o, 32'hA500_0014);
      tick();
      idle_in();
      a_rd_chk("rw_new", 8'd20, 32'hDEAD_BEEF);

      // Out-of-range read @240 and write @255.
      a_req_i = 1; a_wr_i = 0; a_adr_i = 8'd240;
      @(negedge clk);
      chk("oor_gnt", 32'(a_gnt_o), 32'd1);
      chk("oor_ena", 32'({ram_wr_ena_o, ram_rd_ena_o}), 32'd0);
      tick();
      idle_in();
      @(negedge clk);
      chk("oor_err", 32'(err_o), 32'd1);
      chk("oor_vld", 32'(a_rd_vld_o), 32'd0);
      tick();
      @(negedge clk);
      chk("oor_err_end", 32'(err_o), 32'd0);
      a_acc(1'b1, 8'd255, 32'h5555_AAAA);
      chk("oor_wr_mem", mem[255], 32'hA500_00FF);
      a_rd_chk("edge239", 8'd239, 32'hA500_00EF);

      // Zero-fill with a coinciding request, a stray clr_i in the middle.
      a_req_i = 1; a_wr_i = 0; a_adr_i = 8'd0;
      clr_i = 1;
      @(negedge clk);
      chk("clr_nogrant", 32'({a_gnt_o, ram_wr_ena_o, ram_rd_ena_o}), 32'd0);
      tick();
      clr_i = 0;
      for (int i = 0; i < 240; i++) begin
         clr_i = (i == 50);
         @(negedge clk);
         chk("clr_busy", 32'(busy_o), 32'd1);
         chk("clr_adr", 32'(ram_adr_o), 32'(i));
         chk("clr_ena", 32'({ram_wr_ena_o, ram_rd_ena_o, a_gnt_o, b_gnt_o, ram_wr_dat_o != 0}), 32'b10000);
         tick();
      end
      clr_i = 0;
      // Held request is served as soon as the fill ends.
      @(negedge clk);
      chk("clr_done", 32'({busy_o, a_gnt_o}), 32'b01);
      tick();
      idle_in();
      @(negedge clk);
      chk("clr_rd0", rd_dat_o, 32'h0);
      tick();
      a_rd_chk("clr_rd120", 8'd120, 32'h0);
      a_rd_chk("clr_rd239", 8'd239, 32'h0);
      chk("clr_mem240", mem[240], 32'hA500_00F0);

      // Reset at fill cycle 100 aborts the fill.
      a_acc(1'b1, 8'd150, 32'hCAFE_0150);
      a_acc(1'b1, 8'd99,  32'h0000_0099);
      a_acc(1'b1, 8'd100, 32'h0000_0100);
      clr_i = 1;
      tick();
      clr_i = 0;
      for (int i = 0; i < 100; i++) tick();
      rst = 1;
      @(negedge clk);
      chk("abort_ena", 32'(ram_wr_ena_o), 32'd0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("abort_busy", 32'(busy_o), 32'd0);
      tick();
      a_rd_chk("abort_rd150", 8'd150, 32'hCAFE_0150);
      a_rd_chk("abort_rd100", 8'd100, 32'h0000_0100);
      a_rd_chk("abort_rd99",  8'd99,  32'h0);

      // Read in flight when reset hits is dropped.
      a_req_i = 1; a_wr_i = 0; a_adr_i = 8'd3;
      @(negedge clk);
      chk("drop_gnt", 32'(a_gnt_o), 32'd1);
      tick();
      idle_in();
      rst = 1;
      @(negedge clk);
      chk("drop_vld_rst", 32'(a_rd_vld_o), 32'd0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("drop_vld_after", 32'({a_rd_vld_o, b_rd_vld_o, err_o}), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_sp_arb_240x32.md
RAM_SP_ARB_240X32 -- requirements
Module: ram_sp_arb_240x32

Interface
REQ-001 SHALL have parameter ADR_WD, default 8, RAM address width.
REQ-002 SHALL have parameter DAT_WD, default 32, RAM data width.
REQ-003 SHALL have parameter DEPTH, default 240, number of valid RAM words (addresses 0..DEPTH-1).
REQ-004 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset; one clock, synchronous, active-high (fixed).
REQ-006 SHALL have port clr_i, input, 1, pulse starting a zero-fill of all DEPTH words.
REQ-007 SHALL have port busy_o, output, 1, high while zero-fill runs.
REQ-008 SHALL have ports a_req_i / b_req_i, input, 1 each, requester A/B access request.
REQ-009 SHALL have ports a_wr_i / b_wr_i, input, 1 each, 1 = write, 0 = read.
REQ-010 SHALL have ports a_adr_i / b_adr_i, input, ADR_WD each, access address.
REQ-011 SHALL have ports a_dat_i / b_dat_i, input, DAT_WD each, write data.
REQ-012 SHALL have ports a_gnt_o / b_gnt_o, output, 1 each, request accepted this cycle.
REQ-013 SHALL have ports a_rd_vld_o / b_rd_vld_o, output, 1 each, rd_dat_o valid for A/B.
REQ-014 SHALL have port rd_dat_o, output, DAT_WD, read data, equal to ram_rd_dat_i.
REQ-015 SHALL have port err_o, output, 1, one-cycle pulse: out-of-range access was granted.
REQ-016 SHALL have ports ram_adr_o (ADR_WD), ram_wr_ena_o (1), ram_wr_dat_o (DAT_WD), ram_rd_ena_o (1), all outputs, driving the 240x32 single-port RAM.
REQ-017 SHALL have port ram_rd_dat_i, input, DAT_WD, RAM read data, valid one cycle after ram_rd_ena_o.

Function
REQ-018 SHALL implement states IDLE and CLEAR; IDLE -> CLEAR on clr_i=1; CLEAR -> IDLE after writing address DEPTH-1.
REQ-019 SHALL in CLEAR drive ram_wr_ena_o=1, ram_wr_dat_o=0, ram_adr_o=counter 0..DEPTH-1, one word per cycle (exactly DEPTH cycles), busy_o=1, both gnt=0.
REQ-020 SHALL ignore clr_i while in CLEAR; no restart, no extension.
REQ-021 SHALL, when clr_i and any request coincide in IDLE, start CLEAR and grant nothing that cycle.
REQ-022 SHALL in IDLE grant at most one requester per cycle; grant is combinational in the request cycle.
REQ-023 SHALL, with one request, grant it; with both, grant the one not granted most recently (round-robin pointer updates only on a grant).
REQ-024 SHALL require the requester to hold req/wr/adr/dat stable until gnt; deasserting req without gnt is legal and causes no access.
REQ-025 SHALL, on an in-range grant (adr < DEPTH), drive ram_adr_o/ram_wr_dat_o from the winner and assert exactly one of ram_wr_ena_o (wr=1) or ram_rd_ena_o (wr=0) that cycle.
REQ-026 SHALL assert x_rd_vld_o for exactly one cycle, one cycle after an in-range read grant to x; rd_dat_o = ram_rd_dat_i.
REQ-027 SHALL, on an out-of-range grant (adr >= DEPTH), still assert gnt, assert neither RAM enable, produce no rd_vld, and pulse err_o the following cycle.
REQ-028 SHALL keep ram_wr_ena_o and ram_rd_ena_o 0 in any cycle without a grant and outside CLEAR; never both 1.
REQ-029 SHALL support back-to-back grants every cycle, including read followed by write to the same address (read returns the old value).

Reset
REQ-030 SHALL on rst=1 force state IDLE, clear counter 0, round-robin pointer favouring A, busy_o=0, a/b_rd_vld_o=0, err_o=0; gnt and RAM enables 0 while rst=1.
REQ-031 SHALL on rst during CLEAR abort the fill immediately; remaining words keep old contents.
REQ-032 SHALL drop any read in flight at rst (no rd_vld the cycle after reset).

Verification
REQ-033 SHALL cover: rst, then A writes 0x12345678 @ 5, B reads @ 5 -> b_rd_vld_o=1 next cycle, rd_dat_o=0x12345678.
REQ-034 SHALL cover: A and B both request reads for 4 cycles after reset -> grants A,B,A,B; each rd_vld one cycle later to the matching port.
REQ-035 SHALL cover: clr_i pulse -> busy_o=1 for exactly 240 cycles, writes 0 to addresses 0..239, no grants; reads of 0, 120, 239 afterward return 0.
REQ-036 SHALL cover: A reads @ 240 -> a_gnt_o=1, no RAM enable, err_o=1 next cycle, a_rd_vld_o stays 0.
REQ-037 SHALL cover: rst asserted at fill cycle 100 -> busy_o=0 next cycle; address 150 retains its previously written value.
